// File: rtl/apb_bridge_slot_decoder.sv
`timescale 1ns/1ps
// APB3 bridge that decodes a parametrised PADDR field into one of NUM_SLOTS
// downstream selects and re-issues each transfer through a registered stage.
module apb_bridge_slot_decoder #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 32,
    parameter int                   SLOT_BITS  = 4,
    parameter int                   SLOT_LSB   = 24,
    parameter int                   NUM_SLOTS  = 16,
    parameter logic [NUM_SLOTS-1:0] SLOT_MASK  = '1,
    parameter int                   TIMEOUT    = 256,
    parameter int                   TPD        = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL_PM,
    input  logic                  PENABLE_PM,
    input  logic                  PWRITE_PM,
    input  logic [ADDR_WIDTH-1:0] PADDR_PM,
    input  logic [DATA_WIDTH-1:0] PWDATA_PM,
    output logic [DATA_WIDTH-1:0] PRDATA_PM,
    output logic                  PREADY_PM,
    output logic                  PSLVERR_PM,
    output logic [NUM_SLOTS-1:0]  PSEL_SC,
    output logic                  PENABLE_SC,
    output logic                  PWRITE_SC,
    output logic [ADDR_WIDTH-1:0] PADDR_SC,
    output logic [DATA_WIDTH-1:0] PWDATA_SC,
    input  logic [DATA_WIDTH-1:0] PRDATA_SC,
    input  logic                  PREADY_SC,
    input  logic                  PSLVERR_SC,
    output logic                  TIMEOUT_EVT
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int SLOT_SPACE = 2 ** SLOT_BITS;
    // Zero-extending the mask to the full slot space makes out-of-range slots read as unmapped.
    localparam logic [SLOT_SPACE-1:0] MASK_FULL = SLOT_SPACE'(SLOT_MASK);

    localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    if (SLOT_LSB + SLOT_BITS > ADDR_WIDTH || NUM_SLOTS < 1 || NUM_SLOTS > SLOT_SPACE ||
        TIMEOUT < 0 || TPD < 0) begin : g_bad_cfg
        $error("apb_bridge_slot_decoder: inconsistent parameter set");
    end

    logic [1:0]           state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [SLOT_BITS-1:0] req_slot;
    logic                 slot_mapped;
    logic                 setup_phase;
    logic [NUM_SLOTS-1:0] slot_onehot;

    assign req_slot    = PADDR_PM[SLOT_LSB +: SLOT_BITS];
    assign slot_mapped = MASK_FULL[req_slot];
    assign setup_phase = PSEL_PM && !PENABLE_PM;

    always_comb begin
        slot_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_onehot[i] = (req_slot == SLOT_BITS'(i));
        end
    end

    // Outputs are loaded on the same edge as the state they belong to, so each
    // state's bus values are already stable when the next edge samples them.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PRDATA_PM   <= '0;
            PREADY_PM   <= 1'b0;
            PSLVERR_PM  <= 1'b0;
            PSEL_SC     <= '0;
            PENABLE_SC  <= 1'b0;
            PWRITE_SC   <= 1'b0;
            PADDR_SC    <= '0;
            PWDATA_SC   <= '0;
            TIMEOUT_EVT <= 1'b0;
        end else begin
            PREADY_PM   <= 1'b0;
            TIMEOUT_EVT <= 1'b0;
            case (state)
                IDLE: begin
                    if (setup_phase) begin
                        if (slot_mapped) begin
                            state     <= SETUP;
                            PSEL_SC   <= slot_onehot;
                            PADDR_SC  <= PADDR_PM;
                            PWDATA_SC <= PWDATA_PM;
                            PWRITE_SC <= PWRITE_PM;
                        end else begin
                            state      <= RESP;
                            PREADY_PM  <= 1'b1;
                            PSLVERR_PM <= 1'b1;
                            PRDATA_PM  <= '0;
                        end
                    end
                end
                SETUP: begin
                    PENABLE_SC <= 1'b1;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY_SC) begin
                        state      <= RESP;
                        PREADY_PM  <= 1'b1;
                        PSLVERR_PM <= PSLVERR_SC;
                        PRDATA_PM  <= PWRITE_SC ? '0 : PRDATA_SC;
                        PSEL_SC    <= '0;
                        PENABLE_SC <= 1'b0;
                        PWRITE_SC  <= 1'b0;
                        PADDR_SC   <= '0;
                        PWDATA_SC  <= '0;
                    end else if (TIMEOUT != 0 && wait_cnt == CNT_LIMIT) begin
                        state       <= RESP;
                        PREADY_PM   <= 1'b1;
                        PSLVERR_PM  <= 1'b1;
                        PRDATA_PM   <= '0;
                        TIMEOUT_EVT <= 1'b1;
                        PSEL_SC     <= '0;
                        PENABLE_SC  <= 1'b0;
                        PWRITE_SC   <= 1'b0;
                        PADDR_SC    <= '0;
                        PWDATA_SC   <= '0;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    PRDATA_PM  <= '0;
                    PSLVERR_PM <= 1'b0;
                    wait_cnt   <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bridge_slot_decoder.sv
`timescale 1ns/1ps
// Scoreboard bench: dut_a is a 16-slot bridge with an 8-cycle timeout, dut_b a
// 12-slot bridge with slot 3 unmapped and the timeout disabled.
module tb_apb_bridge_slot_decoder;

    localparam logic [31:0] B_RDATA = 32'h1234_5678;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          ready_edge;
        logic        tmo;
        int          c0;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        psel_pm, penable_pm, pwrite_pm, use_b;
    logic [31:0] paddr_pm, pwdata_pm;

    logic [31:0] prdata_a, paddr_sc_a, pwdata_sc_a, prdata_sc_a;
    logic        pready_a, pslverr_a, penable_sc_a, pwrite_sc_a, tmo_a;
    logic        pready_sc_a, pslverr_sc_a;
    logic [15:0] psel_sc_a;

    logic [31:0] prdata_b, paddr_sc_b, pwdata_sc_b;
    logic        pready_b, pslverr_b, penable_sc_b, pwrite_sc_b, tmo_b;
    logic [11:0] psel_sc_b;

    logic [31:0] m_prdata, m_paddr_sc, m_pwdata_sc;
    logic        m_pready, m_pslverr, m_penable_sc, m_pwrite_sc, m_tmo;
    logic [15:0] m_psel_sc;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   slave_waits = 0;
    int   wcnt = 0;
    logic tmo_seen = 1'b0;
    exp_t sb[$];

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    apb_bridge_slot_decoder #(.SLOT_MASK(16'hFFFF), .TIMEOUT(8)) dut_a (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .PSEL_PM(psel_pm && !use_b), .PENABLE_PM(penable_pm), .PWRITE_PM(pwrite_pm),
        .PADDR_PM(paddr_pm), .PWDATA_PM(pwdata_pm),
        .PRDATA_PM(prdata_a), .PREADY_PM(pready_a), .PSLVERR_PM(pslverr_a),
        .PSEL_SC(psel_sc_a), .PENABLE_SC(penable_sc_a), .PWRITE_SC(pwrite_sc_a),
        .PADDR_SC(paddr_sc_a), .PWDATA_SC(pwdata_sc_a),
        .PRDATA_SC(prdata_sc_a), .PREADY_SC(pready_sc_a), .PSLVERR_SC(pslverr_sc_a),
        .TIMEOUT_EVT(tmo_a)
    );

    apb_bridge_slot_decoder #(.NUM_SLOTS(12), .SLOT_MASK(12'hFF7), .TIMEOUT(0)) dut_b (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .PSEL_PM(psel_pm && use_b), .PENABLE_PM(penable_pm), .PWRITE_PM(pwrite_pm),
        .PADDR_PM(paddr_pm), .PWDATA_PM(pwdata_pm),
        .PRDATA_PM(prdata_b), .PREADY_PM(pready_b), .PSLVERR_PM(pslverr_b),
        .PSEL_SC(psel_sc_b), .PENABLE_SC(penable_sc_b), .PWRITE_SC(pwrite_sc_b),
        .PADDR_SC(paddr_sc_b), .PWDATA_SC(pwdata_sc_b),
        .PRDATA_SC(B_RDATA), .PREADY_SC(1'b1), .PSLVERR_SC(1'b0),
        .TIMEOUT_EVT(tmo_b)
    );

    assign m_prdata     = use_b ? prdata_b : prdata_a;
    assign m_pready     = use_b ? pready_b : pready_a;
    assign m_pslverr    = use_b ? pslverr_b : pslverr_a;
    assign m_psel_sc    = use_b ? {4'b0, psel_sc_b} : psel_sc_a;
    assign m_penable_sc = use_b ? penable_sc_b : penable_sc_a;
    assign m_pwrite_sc  = use_b ? pwrite_sc_b : pwrite_sc_a;
    assign m_paddr_sc   = use_b ? paddr_sc_b : paddr_sc_a;
    assign m_pwdata_sc  = use_b ? pwdata_sc_b : pwdata_sc_a;
    assign m_tmo        = use_b ? tmo_b : tmo_a;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Downstream slave for dut_a: raises PREADY_SC after slave_waits access cycles.
    always @(posedge PCLK) begin
        #1;
        if (psel_sc_a != 16'h0 && penable_sc_a) begin
            pready_sc_a = (wcnt == slave_waits);
            wcnt++;
        end else begin
            pready_sc_a = 1'b0;
            wcnt = 0;
        end
    end

    // Response monitor: pops one expectation per upstream PREADY pulse.
    always @(negedge PCLK) begin
        if (m_tmo) tmo_seen = 1'b1;
        if (m_pready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_prdata", m_prdata, e.rdata);
                checkOutput("sb_pslverr", {31'b0, m_pslverr}, {31'b0, e.err});
                checkOutput("sb_ready_edge", 32'(cyc - e.c0 + 1), 32'(e.ready_edge));
                checkOutput("sb_timeout_evt", {31'b0, tmo_seen}, {31'b0, e.tmo});
            end
            tmo_seen = 1'b0;
        end
    end

    task automatic applyStimulus(input bit to_b, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits,
                                 input logic [31:0] srdata, input logic serr);
        int          slot;
        int          nslots;
        logic [15:0] mask;
        logic [15:0] onehot;
        logic        mapped;
        logic        tmo;
        bit          done;
        exp_t        e;
        slot   = int'((addr >> 24) & 32'hF);
        nslots = to_b ? 12 : 16;
        mask   = to_b ? 16'h0FF7 : 16'hFFFF;
        mapped = (slot < nslots) && mask[slot];
        onehot = mapped ? (16'h1 << slot) : 16'h0;
        tmo    = mapped && !to_b && (waits > 8);
        e.err  = !mapped || tmo || (!to_b && serr);
        e.rdata = (!mapped || tmo || wr) ? 32'h0 : (to_b ? B_RDATA : srdata);
        e.ready_edge = !mapped ? 1 : (tmo ? 11 : 3 + (to_b ? 0 : waits));
        e.tmo  = tmo;
        slave_waits  = waits;
        prdata_sc_a  = srdata;
        pslverr_sc_a = serr;
        use_b      = to_b;
        psel_pm    = 1'b1;
        penable_pm = 1'b0;
        pwrite_pm  = wr;
        paddr_pm   = addr;
        pwdata_pm  = wdata;
        @(posedge PCLK);
        #1;
        e.c0 = cyc;
        sb.push_back(e);
        penable_pm = 1'b1;
        @(negedge PCLK);
        checkOutput("psel_sc_t1", {16'h0, m_psel_sc}, {16'h0, onehot});
        checkOutput("penable_sc_t1", {31'b0, m_penable_sc}, 32'd0);
        if (mapped) begin
            checkOutput("paddr_sc", m_paddr_sc, addr);
            checkOutput("pwdata_sc", m_pwdata_sc, wdata);
            checkOutput("pwrite_sc", {31'b0, m_pwrite_sc}, {31'b0, wr});
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i == 1 && mapped) begin
                checkOutput("penable_sc_t2", {31'b0, m_penable_sc}, 32'd1);
                checkOutput("psel_sc_t2", {16'h0, m_psel_sc}, {16'h0, onehot});
            end
            if (m_pready) begin
                done = 1'b1;
                checkOutput("psel_sc_resp", {16'h0, m_psel_sc}, 32'h0);
                checkOutput("penable_sc_resp", {31'b0, m_penable_sc}, 32'h0);
                checkOutput("paddr_sc_resp", m_paddr_sc, 32'h0);
            end else begin
                @(negedge PCLK);
            end
        end
        if (!done) checkOutput("pready_wait_bound", 32'd0, 32'd1);
        @(posedge PCLK);
        #1;
        psel_pm    = 1'b0;
        penable_pm = 1'b0;
        @(negedge PCLK);
        checkOutput("pready_after_resp", {31'b0, m_pready}, 32'd0);
        checkOutput("prdata_after_resp", m_prdata, 32'h0);
        checkOutput("pslverr_after_resp", {31'b0, m_pslverr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        psel_pm = 1'b0; penable_pm = 1'b0; pwrite_pm = 1'b0; use_b = 1'b0;
        paddr_pm = 32'h0; pwdata_pm = 32'h0;
        prdata_sc_a = 32'h0; pslverr_sc_a = 1'b0; pready_sc_a = 1'b0;
        repeat (2) @(negedge PCLK);
        checkOutput("rst_pready", {31'b0, pready_a}, 32'd0);
        checkOutput("rst_psel_sc", {16'h0, psel_sc_a}, 32'h0);
        PRESETN = 1'b1;
        @(negedge PCLK);
        checkOutput("idle_prdata", prdata_a, 32'h0);
        checkOutput("idle_tmo", {31'b0, tmo_a}, 32'd0);

        applyStimulus(1'b0, 1'b1, 32'h0300_0010, 32'hA5A5_1234, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0500_0004, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0300_0000, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0D00_0000, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0200_0020, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0900_0008, 32'h0, 100, 32'h5555_AAAA, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0900_000C, 32'h0, 8, 32'h0BAD_F00D, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0000_0000, 32'h0, 1, 32'hCAFE_0001, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h0F00_0100, 32'h7777_8888, 0, 32'h0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            int unsigned s;
            s = $urandom_range(0, 15);
            applyStimulus(1'b0, 1'($urandom_range(0, 1)),
                          (32'(s) << 24) | ($urandom & 32'h00FF_FFFC), $urandom,
                          int'($urandom_range(0, 4)), $urandom, 1'($urandom_range(0, 1)));
        end

        use_b = 1'b0;
        slave_waits = 5;
        psel_pm = 1'b1; penable_pm = 1'b0; pwrite_pm = 1'b1;
        paddr_pm = 32'h0600_0040; pwdata_pm = 32'h1111_2222;
        @(posedge PCLK);
        #1;
        penable_pm = 1'b1;
        @(posedge PCLK);
        #3;
        PRESETN = 1'b0;
        #1;
        checkOutput("rst_mid_psel_sc", {16'h0, psel_sc_a}, 32'h0);
        checkOutput("rst_mid_penable_sc", {31'b0, penable_sc_a}, 32'd0);
        checkOutput("rst_mid_paddr_sc", paddr_sc_a, 32'h0);
        checkOutput("rst_mid_pwdata_sc", pwdata_sc_a, 32'h0);
        checkOutput("rst_mid_pready", {31'b0, pready_a}, 32'd0);
        psel_pm = 1'b0; penable_pm = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESETN = 1'b1;
        repeat (3) @(negedge PCLK);
        applyStimulus(1'b0, 1'b0, 32'h0700_0010, 32'h0, 2, 32'h0F0F_F0F0, 1'b0);

        repeat (3) @(negedge PCLK);
        checkOutput("sb_leftover", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
